// File: rtl/aes_key_mem.sv
// AES key expansion and round-key store: expands a 128/256-bit cipher key into
// 11/15 round keys, one per cycle, using an S-box shared through a word port.
module aes_key_mem (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sbox_word,
  input  logic [31:0]  new_sbox_word
);

  localparam int NUM_KEYS = 15;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    GENERATE,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     round_ctr_q, round_ctr_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [255:0]   key_q, key_d;
  logic           keylen_q, keylen_d;
  logic           ready_q, ready_d;
  logic [127:0]   key_mem_q [NUM_KEYS];
  logic [127:0]   key_mem_d [NUM_KEYS];

  logic [3:0]     num_rounds;
  logic [127:0]   prev_key;
  logic [127:0]   prev2_key;
  logic [127:0]   base_key;
  logic [127:0]   new_key;
  logic [31:0]    rot_word;
  logic [31:0]    t_word;
  logic [31:0]    w0, w1, w2, w3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign num_rounds = keylen_q ? 4'd14 : 4'd10;
  assign ready      = ready_q;

  // Previous one and two entries relative to the entry being generated.
  always_comb begin
    prev_key  = '0;
    prev2_key = '0;
    if (round_ctr_q != 4'd0) begin
      prev_key = key_mem_q[round_ctr_q - 4'd1];
    end
    if (round_ctr_q >= 4'd2) begin
      prev2_key = key_mem_q[round_ctr_q - 4'd2];
    end
  end

  always_comb begin
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    rcon_d      = rcon_q;
    key_d       = key_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;
    key_mem_d   = key_mem_q;
    sbox_word   = '0;
    new_key     = '0;
    base_key    = '0;
    rot_word    = '0;
    t_word      = '0;
    w0          = '0;
    w1          = '0;
    w2          = '0;
    w3          = '0;

    case (state_q)
      IDLE: begin
        if (init) begin
          key_d    = key;
          keylen_d = keylen;
          ready_d  = 1'b0;
          state_d  = INIT;
        end
      end

      INIT: begin
        round_ctr_d = 4'd0;
        rcon_d      = 8'h01;
        state_d     = GENERATE;
      end

      GENERATE: begin
        if (round_ctr_q == 4'd0) begin
          new_key = key_q[255:128];
        end else if (keylen_q && (round_ctr_q == 4'd1)) begin
          new_key = key_q[127:0];
        end else begin
          sbox_word = prev_key[31:0];
          rot_word  = {new_sbox_word[23:0], new_sbox_word[31:24]} ^ {rcon_q, 24'h0};
          if (!keylen_q) begin
            t_word   = rot_word;
            rcon_d   = xtime(rcon_q);
            base_key = prev_key;
          end else if (!round_ctr_q[0]) begin
            t_word   = rot_word;
            rcon_d   = xtime(rcon_q);
            base_key = prev2_key;
          end else begin
            // AES-256 odd entries substitute without rotation or rcon.
            t_word   = new_sbox_word;
            base_key = prev2_key;
          end
          w0      = base_key[127:96] ^ t_word;
          w1      = base_key[95:64]  ^ w0;
          w2      = base_key[63:32]  ^ w1;
          w3      = base_key[31:0]   ^ w2;
          new_key = {w0, w1, w2, w3};
        end

        key_mem_d[round_ctr_q] = new_key;
        round_ctr_d            = round_ctr_q + 4'd1;
        if (round_ctr_q == num_rounds) begin
          state_d = DONE;
        end
      end

      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      round_ctr_q <= 4'd0;
      rcon_q      <= 8'h00;
      key_q       <= '0;
      keylen_q    <= 1'b0;
      ready_q     <= 1'b1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      rcon_q      <= rcon_d;
      key_q       <= key_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_mem_q[i] <= key_mem_d[i];
      end
    end
  end

  // Index 15 lies beyond the store and reads as zero.
  always_comb begin
    round_key = '0;
    if (round != 4'd15) begin
      round_key = key_mem_q[round];
    end
  end

endmodule

// File: tb/tb_aes_key_mem.sv
// Bench for aes_key_mem: FIPS-197 vectors, busy-init and mid-expansion reset
// sequences, and random keys checked against a word-oriented expansion model.
module tb_aes_key_mem;

  logic         clk;
  logic         reset;
  logic         init;
  logic [255:0] key;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sbox_word;
  logic [31:0]  new_sbox_word;

  int checks;
  int errors;

  logic [7:0]   sbox_tab [256];
  logic [127:0] model_store [16];
  logic [127:0] exp_rk [16];
  logic [127:0] exp_q [$];

  typedef struct {
    logic [255:0] key;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  localparam logic [255:0] A1_KEY = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] A3_KEY =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A3_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_mem dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .key           (key),
    .keylen        (keylen),
    .round         (round),
    .round_key     (round_key),
    .ready         (ready),
    .sbox_word     (sbox_word),
    .new_sbox_word (new_sbox_word)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Shared S-box stand-in
  assign new_sbox_word = {sbox_tab[sbox_word[31:24]], sbox_tab[sbox_word[23:16]],
                          sbox_tab[sbox_word[15:8]],  sbox_tab[sbox_word[7:0]]};

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] b;
    // Multiplicative inverse as x^254; zero maps to zero.
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
    b = inv;
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_calc(w[31:24]), sbox_calc(w[23:16]), sbox_calc(w[15:8]), sbox_calc(w[7:0])};
  endfunction

  // FIPS-197 word-wise key expansion into exp_rk[0..nr]
  task automatic model_expand(input logic [255:0] k, input logic kl);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc;
    int nk;
    int nr;
    nk = kl ? 8 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r < 16; r++) exp_rk[r] = model_store[r];
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_store(input string tag);
    logic [127:0] e;
    for (int r = 0; r < 16; r++) exp_q.push_back((r == 15) ? 128'h0 : model_store[r]);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      round = 4'(r);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s_round%0d", tag, r), round_key, e);
    end
  endtask

  // Driver: one expansion, monitoring sbox_word and latency. busy_at >= 0
  // pulses a second init with k2 while the block is busy.
  task automatic run_expansion(input logic [255:0] k, input logic kl,
                               input int busy_at, input logic [255:0] k2);
    int cycles;
    int nr;
    int gi;
    logic [31:0] exp_sb;
    model_expand(k, kl);
    nr = kl ? 14 : 10;
    key = k;
    keylen = kl;
    init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    check("ready_low_after_init", {127'h0, ready}, 128'h0);
    check("sbox_init_state", {96'h0, sbox_word}, 128'h0);
    cycles = 0;
    while (!ready && cycles < 40) begin
      if (cycles == busy_at) begin
        init = 1'b1;
        key = k2;
        keylen = ~kl;
      end
      @(negedge clk);
      cycles++;
      init = 1'b0;
      if (!ready) begin
        exp_sb = 32'h0;
        if (cycles >= 1 && cycles <= nr + 1) begin
          gi = cycles - 1;
          if ((kl && gi >= 2) || (!kl && gi >= 1)) exp_sb = exp_rk[gi-1][31:0];
        end
        check($sformatf("sbox_cycle%0d", cycles), {96'h0, sbox_word}, {96'h0, exp_sb});
      end
    end
    check("latency", 128'(cycles), 128'(nr + 3));
    check("sbox_idle", {96'h0, sbox_word}, 128'h0);
    for (int r = 0; r < 16; r++) model_store[r] = exp_rk[r];
  endtask

  initial begin
    logic [255:0] last_key;
    logic         last_kl;
    logic         have_run;
    logic [255:0] rk;
    logic         rkl;

    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    for (int r = 0; r < 16; r++) model_store[r] = '0;

    vecs[0] = '{A3_KEY, 1'b1, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
    vecs[1] = '{A3_KEY, 1'b1, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
    vecs[2] = '{A3_KEY, 1'b1, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
    vecs[3] = '{A3_KEY, 1'b1, 4'd14, A3_R14};
    vecs[4] = '{A1_KEY, 1'b0, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[5] = '{A1_KEY, 1'b0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[6] = '{A1_KEY, 1'b0, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[7] = '{A1_KEY, 1'b0, 4'd10, A1_R10};

    reset = 1'b0;
    init = 1'b0;
    key = '0;
    keylen = 1'b0;
    round = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", {127'h0, ready}, 128'h1);
    check("reset_sbox", {96'h0, sbox_word}, 128'h0);
    reset = 1'b1;
    check_store("reset");

    // Table-driven FIPS-197 vectors; AES-256 first so AES-128 overlays it.
    have_run = 1'b0;
    last_key = '0;
    last_kl = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if (!have_run || vecs[v].key != last_key || vecs[v].keylen != last_kl) begin
        run_expansion(vecs[v].key, vecs[v].keylen, -1, '0);
        have_run = 1'b1;
        last_key = vecs[v].key;
        last_kl = vecs[v].keylen;
      end
      @(negedge clk);
      round = vecs[v].round;
      #1;
      check($sformatf("vec%0d", v), round_key, vecs[v].exp);
    end

    // Boundary: stale AES-256 entry 14 survives AES-128 expansion; 15 reads 0.
    @(negedge clk);
    round = 4'd14;
    #1;
    check("stale_round14", round_key, A3_R14);
    round = 4'd15;
    #1;
    check("round15_zero", round_key, 128'h0);
    check_store("mixed");

    // Init pulsed with another key while busy is ignored.
    run_expansion(A1_KEY, 1'b0, 5, A3_KEY);
    @(negedge clk);
    round = 4'd10;
    #1;
    check("busy_init_round10", round_key, A1_R10);
    check_store("busy");

    // Reset mid-expansion aborts to reset values.
    key = A1_KEY;
    keylen = 1'b0;
    init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_ready", {127'h0, ready}, 128'h1);
    check("midreset_sbox", {96'h0, sbox_word}, 128'h0);
    for (int r = 0; r < 16; r++) model_store[r] = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_ready", {127'h0, ready}, 128'h1);
    check_store("post_reset");
    run_expansion(A1_KEY, 1'b0, -1, '0);
    @(negedge clk);
    round = 4'd10;
    #1;
    check("after_reset_round10", round_key, A1_R10);
    check_store("after_reset");

    // Random keys and key lengths against the model.
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      rkl = 1'($urandom_range(0, 1));
      run_expansion(rk, rkl, -1, '0);
      check_store($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
